keypad_entry_ctrl: RTL and testbench

Controller that sequences the keypad row scanner and turns its raw `key_pressed`/`value` outputs into clean, once-per-press key events. It paces row advancement with a scan strobe and freezes scanning while a key is being confirmed or held. It debounces both press and release, and keeps the two most recent hex digits for the dual seven-segment display. It sits between the scanner FSM and the display multiplexer in the Lab 3 top level.

---
 rtl/keypad_entry_ctrl_if.sv | 36 +++
 rtl/keypad_entry_ctrl.sv | 119 +++++++++++
 tb/tb_keypad_entry_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_ctrl_if
// Brief    : Scanner-side and display-side signal bundle for keypad_entry_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_entry_ctrl_if;
    logic       key_pressed;
    logic [3:0] value;
    logic       scan_en;
    logic       new_key;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       busy;

    modport master (
        input  key_pressed,
        input  value,
        output scan_en,
        output new_key,
        output digit_new,
        output digit_old,
        output busy
    );

    modport slave (
        output key_pressed,
        output value,
        input  scan_en,
        input  new_key,
        input  digit_new,
        input  digit_old,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_ctrl
// Brief    : Paces the row scanner and debounces key press/release into events.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  wire                 clk,
    input  wire                 reset,
    keypad_entry_ctrl_if.master bus
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [c_DIV_W-1:0] div_q,       div_d;
    logic [c_CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]         cand_q,      cand_d;
    logic [3:0]         digit_new_q, digit_new_d;
    logic [3:0]         digit_old_q, digit_old_d;
    logic               new_key_q,   new_key_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            cand_q      <= '0;
            digit_new_q <= '0;
            digit_old_q <= '0;
            new_key_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            new_key_q   <= new_key_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;
        new_key_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The divider freezes on detection so the row stays put.
                if (bus.key_pressed) begin
                    cand_d  = bus.value;
                    cnt_d   = '0;
                    state_d = ST_CONFIRM;
                end else if (div_q == c_DIV_LAST) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + c_DIV_W'(1);
                end
            end
            ST_CONFIRM: begin
                if (!bus.key_pressed || (bus.value != cand_q)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == c_CNT_LAST) begin
                    digit_old_d = digit_new_q;
                    digit_new_d = cand_q;
                    new_key_d   = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!bus.key_pressed) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // A re-assertion here is release bounce, not a new press.
                if (bus.key_pressed) begin
                    state_d = ST_HELD;
                end else if (cnt_q == c_CNT_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.scan_en   = reset && (state_q == ST_IDLE) && !bus.key_pressed
                           && (div_q == c_DIV_LAST);
    assign bus.new_key   = new_key_q;
    assign bus.digit_new = digit_new_q;
    assign bus.digit_old = digit_old_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry_ctrl
// Brief    : Directed self-checking bench for keypad_entry_ctrl (SCAN_DIV=4, D=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic se_s;

    keypad_entry_ctrl_if kif ();

    keypad_entry_ctrl #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif.master)
    );

    always #5 clk = ~clk;

    // scan_en is sampled mid-cycle; registered outputs are read 1 ns after the edge.
    task automatic tick();
        @(negedge clk);
        se_s = kif.scan_en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        kif.key_pressed = 1'b0;
        kif.value = 4'h0;
        tick();
        tick();
        n_vec++;
        if ({kif.scan_en, kif.new_key, kif.busy, kif.digit_new, kif.digit_old} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got se=%b nk=%b busy=%b dn=%h do=%h, want all 0",
                     kif.scan_en, kif.new_key, kif.busy, kif.digit_new, kif.digit_old);
        end
        n_vec++;
        if (se_s !== 1'b0) begin
            n_err++;
            $display("FAIL reset_scan_en: got %b want 0", se_s);
        end
        reset = 1'b1;
    endtask

    task automatic test_idle_scan();
        kif.key_pressed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (se_s !== ((i % 4) == 3)) begin
                n_err++;
                $display("FAIL idle_scan_en[%0d]: got %b want %b", i, se_s, ((i % 4) == 3));
            end
            n_vec++;
            if (kif.busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_busy[%0d]: got %b want 0", i, kif.busy);
            end
        end
    endtask

    task automatic test_clean_press();
        int nk_cnt;
        int nk_idx;
        int se_idx;
        bit se_seen;
        nk_cnt = 0; nk_idx = -1; se_idx = -1; se_seen = 1'b0;
        kif.key_pressed = 1'b1;
        kif.value = 4'hA;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (se_s) se_seen = 1'b1;
            if (kif.new_key) begin
                nk_cnt++;
                if (nk_idx < 0) nk_idx = i;
            end
            if (i == 0) begin
                n_vec++;
                if (kif.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL press_busy: got %b want 1", kif.busy);
                end
            end
        end
        kif.key_pressed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (se_s && se_idx < 0) se_idx = i;
            if (kif.new_key) nk_cnt++;
            if (i == 7 || i == 8) begin
                n_vec++;
                if (kif.busy !== (i == 7)) begin
                    n_err++;
                    $display("FAIL clean_release_busy[%0d]: got %b want %b", i, kif.busy, (i == 7));
                end
            end
        end
        n_vec++;
        if (nk_idx !== 8) begin
            n_err++;
            $display("FAIL clean_new_key_edge: got %0d want 8", nk_idx);
        end
        n_vec++;
        if (nk_cnt !== 1) begin
            n_err++;
            $display("FAIL clean_new_key_count: got %0d want 1", nk_cnt);
        end
        n_vec++;
        if (se_seen !== 1'b0) begin
            n_err++;
            $display("FAIL clean_scan_frozen: got strobe=%b want 0", se_seen);
        end
        n_vec++;
        if (se_idx !== 12) begin
            n_err++;
            $display("FAIL clean_scan_resume: got cycle %0d want 12", se_idx);
        end
        n_vec++;
        if ({kif.digit_new, kif.digit_old} !== 8'hA0) begin
            n_err++;
            $display("FAIL clean_digits: got %h%h want A0", kif.digit_new, kif.digit_old);
        end
    endtask

    task automatic test_press_bounce();
        int nk_cnt;
        int nk_idx;
        nk_cnt = 0; nk_idx = -1;
        kif.value = 4'h5;
        for (int i = 0; i < 4; i++) begin
            kif.key_pressed = (i < 3);
            tick();
            if (kif.new_key) nk_cnt++;
        end
        n_vec++;
        if (nk_cnt !== 0 || kif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_burst: got events=%0d busy=%b want 0/0", nk_cnt, kif.busy);
        end
        kif.key_pressed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (kif.new_key) begin
                nk_cnt++;
                if (nk_idx < 0) nk_idx = i;
            end
        end
        n_vec++;
        if (nk_idx !== 8 || nk_cnt !== 1) begin
            n_err++;
            $display("FAIL bounce_new_key: got edge=%0d count=%0d want 8/1", nk_idx, nk_cnt);
        end
        n_vec++;
        if ({kif.digit_new, kif.digit_old} !== 8'h5A) begin
            n_err++;
            $display("FAIL bounce_digits: got %h%h want 5A", kif.digit_new, kif.digit_old);
        end
        kif.key_pressed = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_vec++;
        if (kif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_idle: got busy=%b want 0", kif.busy);
        end
    endtask

    task automatic test_value_glitch();
        int nk_cnt;
        int nk_idx;
        nk_cnt = 0; nk_idx = -1;
        kif.key_pressed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            kif.value = (i < 4) ? 4'h9 : 4'h6;
            tick();
            if (kif.new_key) begin
                nk_cnt++;
                if (nk_idx < 0) nk_idx = i;
            end
            if (i == 4 || i == 5) begin
                n_vec++;
                if (kif.busy !== (i == 5)) begin
                    n_err++;
                    $display("FAIL glitch_busy[%0d]: got %b want %b", i, kif.busy, (i == 5));
                end
            end
        end
        n_vec++;
        if (nk_idx !== 13 || nk_cnt !== 1) begin
            n_err++;
            $display("FAIL glitch_new_key: got edge=%0d count=%0d want 13/1", nk_idx, nk_cnt);
        end
        n_vec++;
        if ({kif.digit_new, kif.digit_old} !== 8'h65) begin
            n_err++;
            $display("FAIL glitch_digits: got %h%h want 65", kif.digit_new, kif.digit_old);
        end
    endtask

    task automatic test_release_bounce();
        int nk_cnt;
        int idle_idx;
        nk_cnt = 0; idle_idx = -1;
        for (int i = 0; i < 14; i++) begin
            kif.key_pressed = (i == 3);
            kif.value = 4'h3;
            tick();
            if (kif.new_key) nk_cnt++;
            if (!kif.busy && idle_idx < 0) idle_idx = i;
        end
        n_vec++;
        if (nk_cnt !== 0) begin
            n_err++;
            $display("FAIL relbounce_new_key: got %0d events want 0", nk_cnt);
        end
        n_vec++;
        if (idle_idx !== 12) begin
            n_err++;
            $display("FAIL relbounce_idle_edge: got %0d want 12", idle_idx);
        end
        n_vec++;
        if ({kif.digit_new, kif.digit_old} !== 8'h65) begin
            n_err++;
            $display("FAIL relbounce_digits: got %h%h want 65", kif.digit_new, kif.digit_old);
        end
    endtask

    task automatic test_reset_mid_confirm();
        int nk_cnt;
        nk_cnt = 0;
        kif.key_pressed = 1'b1;
        kif.value = 4'hD;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (kif.new_key) nk_cnt++;
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({kif.busy, kif.new_key, kif.digit_new, kif.digit_old} !== 10'h000) begin
            n_err++;
            $display("FAIL midreset_state: got busy=%b nk=%b dn=%h do=%h want all 0",
                     kif.busy, kif.new_key, kif.digit_new, kif.digit_old);
        end
        n_vec++;
        if (se_s !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_scan_en: got %b want 0", se_s);
        end
        reset = 1'b1;
        kif.key_pressed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (kif.new_key) nk_cnt++;
        end
        n_vec++;
        if (nk_cnt !== 0 || kif.digit_new !== 4'h0 || kif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_event: got events=%0d dn=%h busy=%b want 0/0/0",
                     nk_cnt, kif.digit_new, kif.busy);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_press_bounce();
        test_value_glitch();
        test_release_bounce();
        test_reset_mid_confirm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
